// File: rtl/apb3_periph_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb3_periph_pkg
// Description : Shared definitions for the APB3 user peripheral: register
//               word offsets, APB slave FSM state encoding and the constant
//               returned by the ID register.
// Revision    : 1.0 - initial release
// ============================================================================
package apb3_periph_pkg;

    // Word index taken from PADDR[4:2]
    localparam logic [2:0] c_word_out     = 3'd0;  // 0x00 OUT      RW
    localparam logic [2:0] c_word_raw     = 3'd1;  // 0x04 RAW      RO
    localparam logic [2:0] c_word_enable  = 3'd2;  // 0x08 ENABLE   RW
    localparam logic [2:0] c_word_pending = 3'd3;  // 0x0C PENDING  RO/W1C
    localparam logic [2:0] c_word_mode    = 3'd4;  // 0x10 MODE     RW
    localparam logic [2:0] c_word_force   = 3'd5;  // 0x14 FORCE    WO
    localparam logic [2:0] c_word_id      = 3'd6;  // 0x18 ID       RO

    localparam logic [31:0] c_id_value = 32'h0A50_0002;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb3_irq_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : apb3_irq_slave_if
// Description : APB3 bus bundle between a master and the interrupt slave.
//               master modport drives PADDR/PSEL/PENABLE/PWRITE/PWDATA,
//               slave modport drives PREADY/PRDATA/PSLVERROR.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb3_irq_slave_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERROR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERROR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERROR
    );
endinterface
`default_nettype wire

// File: rtl/apb3_irq_chan.sv
`default_nettype none
// ============================================================================
// Module      : apb3_irq_chan
// Description : One interrupt channel: two-flop synchroniser, rising-edge
//               detector and sticky pending bit.
// Ports       : clk, rst      - clock / synchronous active-high reset
//               irq_async     - asynchronous interrupt source
//               edge_mode     - 1 = rising edge, 0 = level
//               clear         - W1C strobe (single cycle)
//               force_set     - software set strobe (single cycle)
//               raw           - synchronised source level
//               pending       - pending flag
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_irq_chan (
    input  logic clk,
    input  logic rst,
    input  logic irq_async,
    input  logic edge_mode,
    input  logic clear,
    input  logic force_set,
    output logic raw,
    output logic pending
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pending;
    logic w_set;

    assign w_set = (edge_mode ? (r_sync2 & ~r_prev) : r_sync2) | force_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_sync1   <= irq_async;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            // A set in the same cycle as a clear wins so no event is lost.
            r_pending <= (r_pending & ~clear) | w_set;
        end
    end

    assign raw     = r_sync2;
    assign pending = r_pending;
endmodule
`default_nettype wire

// File: rtl/apb3_irq_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb3_irq_slave
// Description : APB3 user peripheral aggregating NUM_IRQ interrupt sources
//               into apb3Interrupt, with a RW output register and
//               programmable APB wait states.
// Ports       : io_systemClk/io_systemReset - clock, sync active-high reset
//               apb           - APB3 slave bundle
//               irqIn         - asynchronous interrupt sources
//               apb3Out       - user output register
//               apb3Interrupt - registered OR of (pending & enable)
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_irq_slave
    import apb3_periph_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_IRQ     = 8,
    parameter int                    OUT_WIDTH   = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(c_id_value)
) (
    input  logic                 io_systemClk,
    input  logic                 io_systemReset,
    apb3_irq_slave_if.slave      apb,
    input  logic [NUM_IRQ-1:0]   irqIn,
    output logic [OUT_WIDTH-1:0] apb3Out,
    output logic                 apb3Interrupt
);
    localparam logic [3:0] c_wait_load = 4'(WAIT_STATES);

    apb_state_t            r_state;
    apb_state_t            w_state_next;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            w_wait_next;
    logic                  w_ready;
    logic                  w_setup;
    logic                  w_access;
    logic [2:0]            w_word;
    logic                  w_addr_ok;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_rdata;

    logic [OUT_WIDTH-1:0]  r_out;
    logic [NUM_IRQ-1:0]    r_enable;
    logic [NUM_IRQ-1:0]    r_mode;
    logic                  r_irq;
    logic [NUM_IRQ-1:0]    w_raw;
    logic [NUM_IRQ-1:0]    w_pending;
    logic [NUM_IRQ-1:0]    w_clear;
    logic [NUM_IRQ-1:0]    w_force;
    logic                  w_unused;

    assign w_setup  = apb.PSEL & ~apb.PENABLE;
    assign w_access = apb.PSEL &  apb.PENABLE;

    // SETUP means "setup phase seen last cycle", so the first ACCESS cycle
    // is already handled here; PREADY fires there when no waits remain.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        w_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_state_next = ST_SETUP;
                    w_wait_next  = c_wait_load;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (w_access) begin
                    if (r_wait_cnt == 4'd0) begin
                        w_ready      = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_wait_next  = r_wait_cnt - 4'd1;
                        w_state_next = ST_ACCESS;
                    end
                end else if (w_setup) begin
                    w_state_next = ST_SETUP;
                    w_wait_next  = c_wait_load;
                end else begin
                    // Master abandoned the transfer: nothing commits.
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    // Address decode: word offsets 0x00..0x18 inside the first 32 bytes.
    assign w_word    = apb.PADDR[4:2];
    assign w_addr_ok = (apb.PADDR[ADDR_WIDTH-1:5] == '0) && (w_word != 3'd7);
    assign w_wr      = w_ready & apb.PWRITE & w_addr_ok;

    always_comb begin
        w_rdata = '0;
        case (w_word)
            c_word_out:     w_rdata[OUT_WIDTH-1:0] = r_out;
            c_word_raw:     w_rdata[NUM_IRQ-1:0]   = w_raw;
            c_word_enable:  w_rdata[NUM_IRQ-1:0]   = r_enable;
            c_word_pending: w_rdata[NUM_IRQ-1:0]   = w_pending;
            c_word_mode:    w_rdata[NUM_IRQ-1:0]   = r_mode;
            c_word_id:      w_rdata                = ID_VALUE;
            default:        w_rdata                = '0;
        endcase
    end

    assign apb.PREADY    = w_ready;
    assign apb.PRDATA    = (w_ready && w_addr_ok) ? w_rdata : '0;
    assign apb.PSLVERROR = w_ready & ~w_addr_ok;

    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            r_out    <= '0;
            r_enable <= '0;
            r_mode   <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (w_word == c_word_out))    r_out    <= apb.PWDATA[OUT_WIDTH-1:0];
            if (w_wr && (w_word == c_word_enable)) r_enable <= apb.PWDATA[NUM_IRQ-1:0];
            if (w_wr && (w_word == c_word_mode))   r_mode   <= apb.PWDATA[NUM_IRQ-1:0];
            r_irq <= |(w_pending & r_enable);
        end
    end

    assign w_clear = (w_wr && (w_word == c_word_pending)) ? apb.PWDATA[NUM_IRQ-1:0] : '0;
    assign w_force = (w_wr && (w_word == c_word_force))   ? apb.PWDATA[NUM_IRQ-1:0] : '0;

    generate
        for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
            apb3_irq_chan u_chan (
                .clk       (io_systemClk),
                .rst       (io_systemReset),
                .irq_async (irqIn[i]),
                .edge_mode (r_mode[i]),
                .clear     (w_clear[i]),
                .force_set (w_force[i]),
                .raw       (w_raw[i]),
                .pending   (w_pending[i])
            );
        end
    endgenerate

    assign apb3Out       = r_out;
    assign apb3Interrupt = r_irq;

    // Byte-lane bits and write-data bits above the register widths are ignored.
    assign w_unused = ^{apb.PADDR[1:0], apb.PWDATA};
endmodule
`default_nettype wire

// File: tb/tb_apb3_irq_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb3_irq_slave
// Description : Self-checking bench for apb3_irq_slave. Three instances
//               (WAIT_STATES 0, 3, 5) share one set of bus drivers; a
//               select picks which one sees PSEL. Directed vector table
//               plus hand-timed interrupt and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb3_irq_slave;

    logic        clk;
    logic        rst;
    logic [1:0]  dsel;
    logic [11:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [7:0]  irq_in;

    logic [15:0] out0, out3, out5;
    logic        irq0, irq3, irq5;

    logic        pready_m;
    logic [31:0] prdata_m;
    logic        perr_m;

    int total = 0;
    int bad   = 0;

    apb3_irq_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus0 ();
    apb3_irq_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus3 ();
    apb3_irq_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus5 ();

    assign bus0.PADDR = paddr;  assign bus0.PENABLE = penable;
    assign bus0.PWRITE = pwrite; assign bus0.PWDATA = pwdata;
    assign bus0.PSEL = psel & (dsel == 2'd0);
    assign bus3.PADDR = paddr;  assign bus3.PENABLE = penable;
    assign bus3.PWRITE = pwrite; assign bus3.PWDATA = pwdata;
    assign bus3.PSEL = psel & (dsel == 2'd1);
    assign bus5.PADDR = paddr;  assign bus5.PENABLE = penable;
    assign bus5.PWRITE = pwrite; assign bus5.PWDATA = pwdata;
    assign bus5.PSEL = psel & (dsel == 2'd2);

    always_comb begin
        case (dsel)
            2'd0:    begin pready_m = bus0.PREADY; prdata_m = bus0.PRDATA; perr_m = bus0.PSLVERROR; end
            2'd1:    begin pready_m = bus3.PREADY; prdata_m = bus3.PRDATA; perr_m = bus3.PSLVERROR; end
            default: begin pready_m = bus5.PREADY; prdata_m = bus5.PRDATA; perr_m = bus5.PSLVERROR; end
        endcase
    end

    apb3_irq_slave #(.WAIT_STATES(0)) dut0 (
        .io_systemClk(clk), .io_systemReset(rst), .apb(bus0),
        .irqIn(irq_in), .apb3Out(out0), .apb3Interrupt(irq0));
    apb3_irq_slave #(.WAIT_STATES(3)) dut3 (
        .io_systemClk(clk), .io_systemReset(rst), .apb(bus3),
        .irqIn(irq_in), .apb3Out(out3), .apb3Interrupt(irq3));
    apb3_irq_slave #(.WAIT_STATES(5)) dut5 (
        .io_systemClk(clk), .io_systemReset(rst), .apb(bus5),
        .irqIn(irq_in), .apb3Out(out5), .apb3Interrupt(irq5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  d;
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete APB transfer; returns at commit edge + 1.
    task automatic apb_xfer(input logic [1:0] d, input logic [11:0] a, input logic w,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic err, output int waits);
        dsel = d;
        @(posedge clk); #1;
        paddr = a; pwrite = w; pwdata = wd; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0; rd = '0; err = 1'b0;
        forever begin
            @(negedge clk);
            if (pready_m) begin
                rd = prdata_m; err = perr_m;
                break;
            end
            waits++;
            if (waits > 40) begin
                total++; bad++;
                $display("FAIL pready_timeout: got no PREADY after %0d cycles required <=15", waits);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [1:0] d, input logic [11:0] a, input logic [31:0] wd);
        logic [31:0] rd; logic err; int wt;
        apb_xfer(d, a, 1'b1, wd, rd, err, wt);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] d, input logic [11:0] a,
                          input logic [31:0] exp);
        logic [31:0] rd; logic err; int wt;
        apb_xfer(d, a, 1'b0, '0, rd, err, wt);
        check(name, rd, exp);
    endtask

    function automatic vec_t mk(input logic [1:0] d, input logic [11:0] a, input logic w,
                                input logic [31:0] wd, input logic [31:0] er,
                                input logic ee, input int ew);
        vec_t v;
        v.d = d; v.addr = a; v.wr = w; v.wdata = wd;
        v.exp_rd = er; v.exp_err = ee; v.exp_waits = ew;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        logic        err;
        int          wt;

        vecs[0]  = mk(2'd0, 12'h000, 1'b1, 32'h0000_A5A5, 32'h0,          1'b0, 0);
        vecs[1]  = mk(2'd0, 12'h000, 1'b0, 32'h0,         32'h0000_A5A5,  1'b0, 0);
        vecs[2]  = mk(2'd0, 12'h018, 1'b0, 32'h0,         32'h0A50_0002,  1'b0, 0);
        vecs[3]  = mk(2'd1, 12'h018, 1'b0, 32'h0,         32'h0A50_0002,  1'b0, 3);
        vecs[4]  = mk(2'd0, 12'h008, 1'b1, 32'hFFFF_FFFF, 32'h0,          1'b0, 0);
        vecs[5]  = mk(2'd0, 12'h008, 1'b0, 32'h0,         32'h0000_00FF,  1'b0, 0);
        vecs[6]  = mk(2'd0, 12'h008, 1'b1, 32'h0,         32'h0,          1'b0, 0);
        vecs[7]  = mk(2'd0, 12'h01C, 1'b0, 32'h0,         32'h0,          1'b1, 0);
        vecs[8]  = mk(2'd0, 12'h01C, 1'b1, 32'h1234_5678, 32'h0,          1'b1, 0);
        vecs[9]  = mk(2'd0, 12'h400, 1'b1, 32'h0000_FFFF, 32'h0,          1'b1, 0);
        vecs[10] = mk(2'd0, 12'h400, 1'b0, 32'h0,         32'h0,          1'b1, 0);
        vecs[11] = mk(2'd0, 12'h000, 1'b0, 32'h0,         32'h0000_A5A5,  1'b0, 0);
        vecs[12] = mk(2'd0, 12'h014, 1'b0, 32'h0,         32'h0,          1'b0, 0);
        vecs[13] = mk(2'd1, 12'h000, 1'b1, 32'hFFFF_FFFF, 32'h0,          1'b0, 3);
        vecs[14] = mk(2'd1, 12'h000, 1'b0, 32'h0,         32'h0000_FFFF,  1'b0, 3);
        vecs[15] = mk(2'd0, 12'h010, 1'b0, 32'h0,         32'h0,          1'b0, 0);

        rst = 1'b1; dsel = 2'd0; paddr = '0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; irq_in = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_pready", {31'd0, pready_m}, 32'd0);
        check("reset_prdata", prdata_m, 32'd0);
        check("reset_out",    {16'd0, out0}, 32'd0);
        check("reset_irq",    {31'd0, irq0}, 32'd0);

        // Register access table
        for (int i = 0; i < 16; i++) begin
            apb_xfer(vecs[i].d, vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, err, wt);
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i),   {31'd0, err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_waits", i), wt, vecs[i].exp_waits);
        end
        check("out0_value", {16'd0, out0}, 32'h0000_A5A5);
        check("out3_value", {16'd0, out3}, 32'h0000_FFFF);

        // Rising-edge latency and W1C on channel 0
        wr(2'd0, 12'h010, 32'h01);
        wr(2'd0, 12'h008, 32'h01);
        irq_in[0] = 1'b1;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
            if (e == 2) check("irq_edge2", {31'd0, irq0}, 32'd0);
            if (e == 3) check("irq_edge3", {31'd0, irq0}, 32'd1);
        end
        rd_chk("pending_edge", 2'd0, 12'h00C, 32'h01);
        wr(2'd0, 12'h00C, 32'h01);
        check("irq_at_w1c_edge", {31'd0, irq0}, 32'd1);
        @(posedge clk); #1;
        check("irq_after_w1c", {31'd0, irq0}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rd_chk("pending_no_repend", 2'd0, 12'h00C, 32'h00);

        // Level mode re-pend and software force
        irq_in = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        wr(2'd0, 12'h008, 32'h00);
        wr(2'd0, 12'h010, 32'h00);
        irq_in = 8'h04;
        repeat (4) @(posedge clk);
        #1;
        rd_chk("raw_level", 2'd0, 12'h004, 32'h04);
        rd_chk("pending_level", 2'd0, 12'h00C, 32'h04);
        wr(2'd0, 12'h00C, 32'h04);
        rd_chk("pending_repend", 2'd0, 12'h00C, 32'h04);
        wr(2'd0, 12'h014, 32'h80);
        rd_chk("pending_force", 2'd0, 12'h00C, 32'h84);
        check("irq_disabled", {31'd0, irq0}, 32'd0);

        // Edge on channel 1 lands on the same edge as its W1C: set wins
        wr(2'd0, 12'h014, 32'h02);
        wr(2'd0, 12'h010, 32'h02);
        rd_chk("pending_pre_collide", 2'd0, 12'h00C, 32'h86);
        irq_in = 8'h06;
        wr(2'd0, 12'h00C, 32'h02);
        rd_chk("pending_set_wins", 2'd0, 12'h00C, 32'h86);
        rd_chk("out_unchanged", 2'd0, 12'h000, 32'h0000_A5A5);

        // Reset in the middle of a WAIT_STATES=5 access
        wr(2'd2, 12'h000, 32'h1234);
        wr(2'd2, 12'h008, 32'hFF);
        wr(2'd2, 12'h014, 32'h01);
        irq_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("out5_value", {16'd0, out5}, 32'h0000_1234);
        check("irq5_forced", {31'd0, irq5}, 32'd1);
        dsel = 2'd2;
        @(posedge clk); #1;
        paddr = 12'h000; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("wait_no_pready", {31'd0, pready_m}, 32'd0);
        check("wait_prdata_zero", prdata_m, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_pready", {31'd0, pready_m}, 32'd0);
        check("rst_out5", {16'd0, out5}, 32'd0);
        check("rst_irq5", {31'd0, irq5}, 32'd0);
        check("rst_out0", {16'd0, out0}, 32'd0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        rd_chk("rst_enable5", 2'd2, 12'h008, 32'h0);
        rd_chk("rst_pending5", 2'd2, 12'h00C, 32'h0);
        rd_chk("rst_out5_reg", 2'd2, 12'h000, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
